// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Complete-stage arbiter that collects finished results from the functional
// units and broadcasts up to SCALAR_WIDTH of them per cycle on the common
// data bus. Each FU owns a one-entry holding buffer behind a ready/valid
// handshake, so a losing FU stalls rather than dropping its result. Lane
// grants rotate round-robin across FUs so no unit starves.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-low reset
//   squash         in   flush; drops pending and outgoing results
//   fu_done_valid  in   [NUM_FU]                 FU i presents a result
//   fu_done_pdest  in   [NUM_FU*PREG_IDX_WIDTH]  destination tag per FU
//   fu_done_value  in   [NUM_FU*XLEN]            result data per FU
//   fu_done_ready  out  [NUM_FU]                 result accepted at next edge
//   cdb_valid      out  [SCALAR_WIDTH]           lane broadcast valid
//   cdb_tag        out  [SCALAR_WIDTH*PREG_IDX_WIDTH] broadcast tag
//   cdb_value      out  [SCALAR_WIDTH*XLEN]      broadcast data
module cdb_arbiter #(
  parameter int NUM_FU         = 4,
  parameter int SCALAR_WIDTH   = 2,
  parameter int PREG_IDX_WIDTH = 6,
  parameter int XLEN           = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               squash,
  input  logic [NUM_FU-1:0]                  fu_done_valid,
  input  logic [NUM_FU*PREG_IDX_WIDTH-1:0]   fu_done_pdest,
  input  logic [NUM_FU*XLEN-1:0]             fu_done_value,
  output logic [NUM_FU-1:0]                  fu_done_ready,
  output logic [SCALAR_WIDTH-1:0]            cdb_valid,
  output logic [SCALAR_WIDTH*PREG_IDX_WIDTH-1:0] cdb_tag,
  output logic [SCALAR_WIDTH*XLEN-1:0]       cdb_value
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]         hold_valid;
  logic [PREG_IDX_WIDTH-1:0] hold_pdest [NUM_FU];
  logic [XLEN-1:0]           hold_value [NUM_FU];
  logic [PTR_W-1:0]          rr_ptr;

  logic [PREG_IDX_WIDTH-1:0] in_pdest [NUM_FU];
  logic [XLEN-1:0]           in_value [NUM_FU];

  logic [NUM_FU-1:0]         grant;
  logic [SCALAR_WIDTH-1:0]   lane_used;
  logic [PTR_W-1:0]          lane_fu [SCALAR_WIDTH];
  logic [PTR_W-1:0]          last_fu;
  logic [PTR_W-1:0]          rr_next;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      in_pdest[i] = fu_done_pdest[i*PREG_IDX_WIDTH +: PREG_IDX_WIDTH];
      in_value[i] = fu_done_value[i*XLEN +: XLEN];
    end
  end

  // Scan buffers starting at rr_ptr, wrapping around; the n-th occupied
  // buffer found takes lane n. Only registered state feeds this, so the
  // grant is independent of the FUs' current-cycle inputs.
  always_comb begin
    int               cnt;
    int               pos;
    logic [PTR_W-1:0] idx;
    grant     = '0;
    lane_used = '0;
    last_fu   = '0;
    cnt       = 0;
    for (int l = 0; l < SCALAR_WIDTH; l++) lane_fu[l] = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_FU) pos = pos - NUM_FU;
      idx = PTR_W'(pos);
      if (hold_valid[idx] && cnt < SCALAR_WIDTH) begin
        grant[idx] = 1'b1;
        for (int l = 0; l < SCALAR_WIDTH; l++) begin
          if (l == cnt) begin
            lane_used[l] = 1'b1;
            lane_fu[l]   = idx;
          end
        end
        last_fu = idx;
        cnt     = cnt + 1;
      end
    end
  end

  // Next pointer resumes just past the last FU that won a lane.
  assign rr_next = (last_fu == PTR_W'(NUM_FU - 1)) ? '0 : last_fu + PTR_W'(1);

  // A draining buffer can take its FU's next result in the same cycle.
  assign fu_done_ready = reset ? (~hold_valid | grant) : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        hold_pdest[i] <= '0;
        hold_value[i] <= '0;
      end
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      rr_ptr    <= '0;
    end else if (squash) begin
      // Inputs accepted on a squash edge are discarded along with everything pending.
      hold_valid <= '0;
      cdb_valid  <= '0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int l = 0; l < SCALAR_WIDTH; l++) begin
        if (lane_used[l]) begin
          cdb_valid[l]                                   <= 1'b1;
          cdb_tag[l*PREG_IDX_WIDTH +: PREG_IDX_WIDTH]    <= hold_pdest[lane_fu[l]];
          cdb_value[l*XLEN +: XLEN]                      <= hold_value[lane_fu[l]];
        end else begin
          cdb_valid[l]                                   <= 1'b0;
          cdb_tag[l*PREG_IDX_WIDTH +: PREG_IDX_WIDTH]    <= '0;
          cdb_value[l*XLEN +: XLEN]                      <= '0;
        end
      end
      // Tag 0 completes the handshake but is never stored, so it is never broadcast.
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_done_valid[i] && fu_done_ready[i]) begin
          hold_valid[i] <= (in_pdest[i] != '0);
          hold_pdest[i] <= in_pdest[i];
          hold_value[i] <= in_value[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      if (|grant) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter. A behavioural model keeps per-FU
// pending results and a rotating start index; each cycle it lists pending
// FUs in rotated order and broadcasts the first two.
module tb_cdb_arbiter;

  localparam int NF = 4;
  localparam int SW = 2;
  localparam int PW = 6;
  localparam int XW = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              squash = 1'b0;
  logic [NF-1:0]     fu_done_valid = '0;
  logic [NF*PW-1:0]  fu_done_pdest = '0;
  logic [NF*XW-1:0]  fu_done_value = '0;
  logic [NF-1:0]     fu_done_ready;
  logic [SW-1:0]     cdb_valid;
  logic [SW*PW-1:0]  cdb_tag;
  logic [SW*XW-1:0]  cdb_value;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_hv  [NF];
  logic [PW-1:0] m_pd [NF];
  logic [XW-1:0] m_val [NF];
  int          m_rr;
  int          m_gq [$];
  logic [NF-1:0]    exp_ready;
  logic [SW-1:0]    exp_cv;
  logic [SW*PW-1:0] exp_tag;
  logic [SW*XW-1:0] exp_val;

  cdb_arbiter #(.NUM_FU(NF), .SCALAR_WIDTH(SW), .PREG_IDX_WIDTH(PW), .XLEN(XW)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_done_valid(fu_done_valid), .fu_done_pdest(fu_done_pdest), .fu_done_value(fu_done_value),
    .fu_done_ready(fu_done_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value)
  );

  always #5 clock = ~clock;

  function automatic bit is_granted(int f);
    foreach (m_gq[j]) if (m_gq[j] == f) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs and predict which FUs are ready.
  task automatic applyStimulus(input logic [NF-1:0] v, input logic [NF*PW-1:0] pd,
                               input logic [NF*XW-1:0] val, input logic sq, input logic rst);
    fu_done_valid = v;
    fu_done_pdest = pd;
    fu_done_value = val;
    squash = sq;
    reset = rst;
    m_gq.delete();
    for (int k = 0; k < NF; k++) begin
      int f;
      f = (m_rr + k) % NF;
      if (m_hv[f] && m_gq.size() < SW) m_gq.push_back(f);
    end
    for (int i = 0; i < NF; i++) exp_ready[i] = rst && (!m_hv[i] || is_granted(i));
    #1;
  endtask

  // Advance the model across a rising edge.
  task automatic edge_step();
    @(posedge clock);
    if (!reset) begin
      for (int i = 0; i < NF; i++) m_hv[i] = 1'b0;
      exp_cv = '0; exp_tag = '0; exp_val = '0; m_rr = 0;
    end else if (squash) begin
      for (int i = 0; i < NF; i++) m_hv[i] = 1'b0;
      exp_cv = '0; exp_tag = '0; exp_val = '0; m_rr = 0;
    end else begin
      exp_cv = '0; exp_tag = '0; exp_val = '0;
      for (int l = 0; l < m_gq.size(); l++) begin
        exp_cv[l] = 1'b1;
        exp_tag[l*PW +: PW] = m_pd[m_gq[l]];
        exp_val[l*XW +: XW] = m_val[m_gq[l]];
      end
      for (int i = 0; i < NF; i++) begin
        if (fu_done_valid[i] && exp_ready[i]) begin
          m_hv[i]  = (fu_done_pdest[i*PW +: PW] != 0);
          m_pd[i]  = fu_done_pdest[i*PW +: PW];
          m_val[i] = fu_done_value[i*XW +: XW];
        end else if (is_granted(i)) begin
          m_hv[i] = 1'b0;
        end
      end
      if (m_gq.size() > 0) m_rr = (m_gq[m_gq.size()-1] + 1) % NF;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'hF, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
      n_checks++;
      if (fu_done_ready !== 4'b0000) begin
        n_errors++;
        $display("[TB] FAIL reset_ready: got %b, expected 0000", fu_done_ready);
      end
      edge_step();
      n_checks++;
      if (cdb_valid !== 2'b00 || cdb_tag !== '0 || cdb_value !== '0) begin
        n_errors++;
        $display("[TB] FAIL reset_cdb: got valid=%b tag=%h value=%h, expected all zero", cdb_valid, cdb_tag, cdb_value);
      end
    end
    applyStimulus('0, '0, '0, 1'b0, 1'b1);
    n_checks++;
    if (fu_done_ready !== 4'b1111) begin
      n_errors++;
      $display("[TB] FAIL post_reset_ready: got %b, expected 1111", fu_done_ready);
    end
    edge_step();
    n_checks++;
    if (cdb_valid !== 2'b00) begin
      n_errors++;
      $display("[TB] FAIL post_reset_cdb: got valid=%b, expected 00", cdb_valid);
    end
  endtask

  task automatic test_single();
    logic [NF*PW-1:0] pd;
    logic [NF*XW-1:0] val;
    pd = '0; val = '0;
    pd[2*PW +: PW] = 6'd5;
    val[2*XW +: XW] = 32'hAB;
    applyStimulus(4'b0100, pd, val, 1'b0, 1'b1);
    edge_step();
    for (int c = 0; c < 3; c++) begin
      applyStimulus('0, '0, '0, 1'b0, 1'b1);
      edge_step();
      n_checks++;
      if (cdb_valid !== exp_cv || cdb_tag !== exp_tag || cdb_value !== exp_val ||
          (c == 0 && (cdb_valid !== 2'b01 || cdb_tag[PW-1:0] !== 6'd5 || cdb_value[XW-1:0] !== 32'hAB)) ||
          (c != 0 && cdb_valid !== 2'b00)) begin
        n_errors++;
        $display("[TB] FAIL single_c%0d: got valid=%b tag=%h value=%h, expected valid=%b tag=%h value=%h",
                 c, cdb_valid, cdb_tag, cdb_value, exp_cv, exp_tag, exp_val);
      end
    end
  endtask

  task automatic test_contention();
    logic [NF*PW-1:0] pd;
    logic [NF*XW-1:0] val;
    logic [SW*PW-1:0] want_tag [3];
    logic [NF-1:0]    want_ready [3];
    want_tag[0] = '0;              want_ready[0] = 4'b1111;
    want_tag[1] = {6'd2, 6'd1};    want_ready[1] = 4'b0011;
    want_tag[2] = {6'd4, 6'd3};    want_ready[2] = 4'b1111;
    applyStimulus('0, '0, '0, 1'b1, 1'b1);
    edge_step();
    for (int i = 0; i < NF; i++) begin
      pd[i*PW +: PW] = PW'(i + 1);
      val[i*XW +: XW] = 32'h100 + i;
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 0) applyStimulus(4'hF, pd, val, 1'b0, 1'b1);
      else        applyStimulus('0, '0, '0, 1'b0, 1'b1);
      n_checks++;
      if (fu_done_ready !== exp_ready || (c < 3 && fu_done_ready !== want_ready[c])) begin
        n_errors++;
        $display("[TB] FAIL contention_ready_c%0d: got %b, expected %b", c, fu_done_ready, exp_ready);
      end
      edge_step();
      n_checks++;
      if (cdb_valid !== exp_cv || cdb_tag !== exp_tag || cdb_value !== exp_val ||
          (c == 1 || c == 2) && (cdb_valid !== 2'b11 || cdb_tag !== want_tag[c])) begin
        n_errors++;
        $display("[TB] FAIL contention_cdb_c%0d: got valid=%b tag=%h, expected valid=%b tag=%h",
                 c, cdb_valid, cdb_tag, exp_cv, exp_tag);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] seq [NF];
    logic [NF*PW-1:0] pd;
    logic [NF*XW-1:0] val;
    int cnt [NF];
    applyStimulus('0, '0, '0, 1'b1, 1'b1);
    edge_step();
    for (int i = 0; i < NF; i++) begin
      seq[i] = 4'd1; cnt[i] = 0;
      pd[i*PW +: PW] = {2'(i), seq[i]};
      val[i*XW +: XW] = $urandom;
    end
    for (int c = 0; c < 11; c++) begin
      logic [NF-1:0] acc;
      applyStimulus((c < 8) ? 4'hF : 4'h0, pd, val, 1'b0, 1'b1);
      acc = exp_ready;
      edge_step();
      n_checks++;
      if (cdb_valid !== exp_cv || cdb_tag !== exp_tag || cdb_value !== exp_val) begin
        n_errors++;
        $display("[TB] FAIL fairness_cdb_c%0d: got valid=%b tag=%h, expected valid=%b tag=%h",
                 c, cdb_valid, cdb_tag, exp_cv, exp_tag);
      end
      if (c >= 1 && c <= 8) begin
        for (int l = 0; l < SW; l++) if (cdb_valid[l]) cnt[cdb_tag[l*PW+4 +: 2]]++;
        n_checks++;
        if (cdb_valid !== 2'b11 || cdb_tag[PW-1 -: 2] !== ((c % 2) ? 2'd0 : 2'd2) ||
            cdb_tag[2*PW-1 -: 2] !== ((c % 2) ? 2'd1 : 2'd3)) begin
          n_errors++;
          $display("[TB] FAIL fairness_pair_c%0d: got valid=%b tag=%h, expected pair %s",
                   c, cdb_valid, cdb_tag, (c % 2) ? "{0,1}" : "{2,3}");
        end
      end
      for (int i = 0; i < NF; i++) begin
        if (acc[i]) begin
          seq[i] = seq[i] + 4'd1;
          pd[i*PW +: PW] = {2'(i), seq[i]};
          val[i*XW +: XW] = $urandom;
        end
      end
    end
    for (int i = 0; i < NF; i++) begin
      n_checks++;
      if (cnt[i] !== 4) begin
        n_errors++;
        $display("[TB] FAIL fairness_count_fu%0d: got %0d broadcasts, expected 4", i, cnt[i]);
      end
    end
  endtask

  task automatic test_zero_tag();
    logic [NF*PW-1:0] pd;
    logic [NF*XW-1:0] val;
    pd = '0; val = '0;
    pd[0 +: PW] = 6'd7;  val[0 +: XW] = 32'h77;
    pd[PW +: PW] = 6'd0; val[XW +: XW] = 32'h11;
    applyStimulus(4'b0011, pd, val, 1'b0, 1'b1);
    edge_step();
    applyStimulus('0, '0, '0, 1'b0, 1'b1);
    n_checks++;
    if (fu_done_ready !== exp_ready || fu_done_ready[1] !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL zero_tag_ready: got %b, expected %b", fu_done_ready, exp_ready);
    end
    edge_step();
    n_checks++;
    if (cdb_valid !== 2'b01 || cdb_tag[PW-1:0] !== 6'd7 || cdb_value[XW-1:0] !== 32'h77 || cdb_tag !== exp_tag) begin
      n_errors++;
      $display("[TB] FAIL zero_tag_cdb: got valid=%b tag=%h value=%h, expected valid=01 tag=%h value=00000077",
               cdb_valid, cdb_tag, cdb_value, exp_tag);
    end
    applyStimulus('0, '0, '0, 1'b0, 1'b1);
    edge_step();
    n_checks++;
    if (cdb_valid !== 2'b00) begin
      n_errors++;
      $display("[TB] FAIL zero_tag_after: got valid=%b, expected 00", cdb_valid);
    end
  endtask

  task automatic test_squash();
    logic [NF*PW-1:0] pd;
    logic [NF*XW-1:0] val;
    applyStimulus('0, '0, '0, 1'b1, 1'b1);
    edge_step();
    for (int i = 0; i < NF; i++) begin
      pd[i*PW +: PW] = PW'(10 + i);
      val[i*XW +: XW] = $urandom;
    end
    applyStimulus(4'hF, pd, val, 1'b0, 1'b1);
    edge_step();
    pd[0 +: PW] = 6'd20;
    applyStimulus(4'b0001, pd, val, 1'b0, 1'b1);
    edge_step();
    n_checks++;
    if (cdb_valid !== 2'b11 || cdb_tag !== {6'd11, 6'd10}) begin
      n_errors++;
      $display("[TB] FAIL squash_setup: got valid=%b tag=%h, expected valid=11 tag=%h", cdb_valid, cdb_tag, {6'd11, 6'd10});
    end
    pd[PW +: PW] = 6'd30;
    applyStimulus(4'b0010, pd, val, 1'b1, 1'b1);
    n_checks++;
    if (fu_done_ready !== exp_ready) begin
      n_errors++;
      $display("[TB] FAIL squash_ready_during: got %b, expected %b", fu_done_ready, exp_ready);
    end
    edge_step();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (cdb_valid !== 2'b00 || cdb_valid !== exp_cv) begin
        n_errors++;
        $display("[TB] FAIL squash_cdb_c%0d: got valid=%b tag=%h, expected valid=00", c, cdb_valid, cdb_tag);
      end
      applyStimulus('0, '0, '0, 1'b0, 1'b1);
      if (c == 0) begin
        n_checks++;
        if (fu_done_ready !== 4'b1111) begin
          n_errors++;
          $display("[TB] FAIL squash_ready_after: got %b, expected 1111", fu_done_ready);
        end
      end
      edge_step();
    end
  endtask

  task automatic test_random();
    logic [NF-1:0]   pv;
    logic [PW-1:0]   ppd [NF];
    logic [XW-1:0]   pval [NF];
    logic [NF*PW-1:0] pd;
    logic [NF*XW-1:0] val;
    logic [NF-1:0]   acc;
    logic            sq;
    logic            rst;
    pv = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NF; i++) begin
        if (!pv[i]) begin
          pv[i]   = ($urandom_range(0, 2) != 0);
          ppd[i]  = PW'($urandom_range(0, 63));
          pval[i] = $urandom;
        end
        pd[i*PW +: PW]  = ppd[i];
        val[i*XW +: XW] = pval[i];
      end
      sq  = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 99) != 0);
      applyStimulus(pv, pd, val, sq, rst);
      acc = exp_ready;
      n_checks++;
      if (fu_done_ready !== exp_ready) begin
        n_errors++;
        $display("[TB] FAIL random_ready_c%0d: got %b, expected %b", c, fu_done_ready, exp_ready);
      end
      edge_step();
      n_checks++;
      if (cdb_valid !== exp_cv || cdb_tag !== exp_tag || cdb_value !== exp_val) begin
        n_errors++;
        $display("[TB] FAIL random_cdb_c%0d: got valid=%b tag=%h value=%h, expected valid=%b tag=%h value=%h",
                 c, cdb_valid, cdb_tag, cdb_value, exp_cv, exp_tag, exp_val);
      end
      pv = pv & ~acc;
    end
  endtask

  initial begin
    m_rr = 0;
    exp_cv = '0; exp_tag = '0; exp_val = '0; exp_ready = '0;
    for (int i = 0; i < NF; i++) begin
      m_hv[i] = 1'b0; m_pd[i] = '0; m_val[i] = '0;
    end
    test_reset();
    test_contention();
    test_single();
    test_zero_tag();
    test_fairness();
    test_squash();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
